mfp_clock_mode_select: RTL and testbench



---
 rtl/mfp_clock_mode_select_pkg.sv | 31 +++
 rtl/mfp_clock_mode_select_if.sv | 24 ++
 rtl/mfp_button_debouncer.sv | 43 ++++
 rtl/mfp_clock_mode_select.sv | 90 +++++++++
 tb/tb_mfp_clock_mode_select.sv | 167 ++++++++++++++++
 5 files changed

// File: rtl/mfp_clock_mode_select_pkg.sv
// Shared mode encoding, controller states and the mode stepping rule.
package mfp_clock_mode_select_pkg;

    typedef logic [1:0] mode_t;

    localparam mode_t MODE_MIN = 2'd0;
    localparam mode_t MODE_MAX = 2'd3;

    typedef enum logic {
        IDLE = 1'b0,
        HOLD = 1'b1
    } state_t;

    typedef struct packed {
        logic  chg;
        mode_t mode;
    } mode_step_t;

    // One step up or down; with wrap off a step past a limit reports no change.
    function automatic mode_step_t mode_step(mode_t cur, logic up, logic wrap);
        mode_step_t r;
        r.chg  = 1'b1;
        r.mode = up ? cur + 2'd1 : cur - 2'd1;
        if (!wrap && ((up && cur == MODE_MAX) || (!up && cur == MODE_MIN))) begin
            r.chg  = 1'b0;
            r.mode = cur;
        end
        return r;
    endfunction

endpackage

// File: rtl/mfp_clock_mode_select_if.sv
// Button inputs and mode select outputs between the board and the divider control.
interface mfp_clock_mode_select_if;
    logic       btn_up;
    logic       btn_down;
    logic [1:0] mode;
    logic       mode_change;
    logic       busy;

    modport master (
        output btn_up,
        output btn_down,
        input  mode,
        input  mode_change,
        input  busy
    );

    modport slave (
        input  btn_up,
        input  btn_down,
        output mode,
        output mode_change,
        output busy
    );
endinterface

// File: rtl/mfp_button_debouncer.sv
// Purpose: 2-FF synchronizer, run-length debouncer and registered press pulse for one button.
// Latency: press pulse DEBOUNCE_CYCLES+2 edges after the raw edge is first sampled.
// Backpressure: none; presses are single-cycle events and are not held.
module mfp_button_debouncer #(
    parameter int DEBOUNCE_CYCLES = 16
) (
    input  logic gclk,
    input  logic rst_n,
    input  logic btn,
    output logic press
);
    localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CW-1:0] RUN_LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic [1:0]    sync;
    logic [CW-1:0] run;
    logic          stable;
    logic          stable_d;

    always_ff @(posedge gclk or negedge rst_n) begin
        if (!rst_n) begin
            sync     <= 2'b00;
            run      <= '0;
            stable   <= 1'b0;
            stable_d <= 1'b0;
            press    <= 1'b0;
        end else begin
            sync <= {sync[0], btn};
            // Any sample agreeing with the accepted level restarts the run.
            if (sync[1] == stable) begin
                run <= '0;
            end else if (run == RUN_LAST) begin
                stable <= sync[1];
                run    <= '0;
            end else begin
                run <= run + CW'(1);
            end
            stable_d <= stable;
            press    <= stable & ~stable_d;
        end
    end

endmodule

// File: rtl/mfp_clock_mode_select.sv
// Purpose: steps the divider mode on debounced up/down presses, then holds off while the clock settles.
// Latency: mode updates one edge after the press pulse; busy lasts HOLDOFF_CYCLES cycles.
// Backpressure: presses arriving while busy, or up+down together, are dropped, never queued.
module mfp_clock_mode_select
    import mfp_clock_mode_select_pkg::*;
#(
    parameter int    DEBOUNCE_CYCLES = 16,
    parameter int    HOLDOFF_CYCLES  = 1024,
    parameter mode_t RESET_MODE      = 2'b00,
    parameter bit    WRAP            = 1'b1
) (
    input  logic                          gclk,
    input  logic                          rst_n,
    mfp_clock_mode_select_if.slave        bus
);
    localparam int HW = (HOLDOFF_CYCLES > 1) ? $clog2(HOLDOFF_CYCLES) : 1;
    localparam logic [HW-1:0] HOLD_LAST = HW'(HOLDOFF_CYCLES - 1);

    logic          up_press;
    logic          dn_press;
    state_t        state_q, state_d;
    mode_t         mode_q, mode_d;
    logic [HW-1:0] hold_q, hold_d;
    logic          mc_q, mc_d;
    mode_step_t    stp;

    mfp_button_debouncer #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_db_up (
        .gclk  (gclk),
        .rst_n (rst_n),
        .btn   (bus.btn_up),
        .press (up_press)
    );

    mfp_button_debouncer #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_db_down (
        .gclk  (gclk),
        .rst_n (rst_n),
        .btn   (bus.btn_down),
        .press (dn_press)
    );

    always_ff @(posedge gclk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            mode_q  <= RESET_MODE;
            hold_q  <= '0;
            mc_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            mode_q  <= mode_d;
            hold_q  <= hold_d;
            mc_q    <= mc_d;
        end
    end

    always_comb begin
        state_d = state_q;
        mode_d  = mode_q;
        hold_d  = hold_q;
        mc_d    = 1'b0;
        stp     = mode_step(mode_q, up_press, WRAP);
        case (state_q)
            IDLE: begin
                // A saturated press is a no-op: no pulse and no hold-off.
                if ((up_press ^ dn_press) && stp.chg) begin
                    mode_d  = stp.mode;
                    mc_d    = 1'b1;
                    hold_d  = HOLD_LAST;
                    state_d = HOLD;
                end
            end
            HOLD: begin
                if (hold_q == '0) begin
                    state_d = IDLE;
                end else begin
                    hold_d = hold_q - HW'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign bus.mode        = mode_q;
    assign bus.mode_change = mc_q;
    assign bus.busy        = (state_q == HOLD);

endmodule

// File: tb/tb_mfp_clock_mode_select.sv
// Directed bench: three instances (wrap from 0, saturate from 0, wrap from 2) share one button stimulus.
module tb_mfp_clock_mode_select;

    logic gclk;
    logic rst_n;
    logic up;
    logic dn;
    int   total;
    int   bad;

    mfp_clock_mode_select_if ifa ();
    mfp_clock_mode_select_if ifb ();
    mfp_clock_mode_select_if ifc ();

    assign ifa.btn_up   = up;
    assign ifa.btn_down = dn;
    assign ifb.btn_up   = up;
    assign ifb.btn_down = dn;
    assign ifc.btn_up   = up;
    assign ifc.btn_down = dn;

    mfp_clock_mode_select #(
        .DEBOUNCE_CYCLES(4), .HOLDOFF_CYCLES(8), .RESET_MODE(2'b00), .WRAP(1'b1)
    ) dut_a (
        .gclk(gclk), .rst_n(rst_n), .bus(ifa)
    );

    mfp_clock_mode_select #(
        .DEBOUNCE_CYCLES(4), .HOLDOFF_CYCLES(8), .RESET_MODE(2'b00), .WRAP(1'b0)
    ) dut_b (
        .gclk(gclk), .rst_n(rst_n), .bus(ifb)
    );

    mfp_clock_mode_select #(
        .DEBOUNCE_CYCLES(4), .HOLDOFF_CYCLES(8), .RESET_MODE(2'b10), .WRAP(1'b1)
    ) dut_c (
        .gclk(gclk), .rst_n(rst_n), .bus(ifc)
    );

    initial gclk = 1'b0;
    always #5 gclk = ~gclk;

    function automatic logic [5:0] modes();
        return {ifa.mode, ifb.mode, ifc.mode};
    endfunction

    function automatic logic [5:0] mcs();
        return {3'b000, ifa.mode_change, ifb.mode_change, ifc.mode_change};
    endfunction

    function automatic logic [5:0] busys();
        return {3'b000, ifa.busy, ifb.busy, ifc.busy};
    endfunction

    task automatic step(input int n);
        repeat (n) @(posedge gclk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [5:0] obs, input logic [5:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    initial begin
        total = 0;
        bad   = 0;
        rst_n = 1'b0;
        up    = 1'b0;
        dn    = 1'b0;
        step(3);
        chk("rst_mode", modes(), {2'd0, 2'd0, 2'd2});
        chk("rst_mc",   mcs(),   6'd0);
        chk("rst_busy", busys(), 6'd0);
        rst_n = 1'b1;
        step(2);

        // Down press: a wraps 0->3, b saturates at 0, c 2->1. Raw edge first sampled at k.
        dn = 1'b1; step(4); dn = 1'b0; step(3);          // at k+6
        chk("dn_pre_mode", modes(), {2'd0, 2'd0, 2'd2});
        chk("dn_pre_mc",   mcs(),   6'd0);
        step(1);                                          // at k+7
        chk("dn_mode", modes(), {2'd3, 2'd0, 2'd1});
        chk("dn_mc",   mcs(),   6'b000101);
        chk("dn_busy", busys(), 6'b000101);
        step(1);
        chk("dn_mc_off",   mcs(),   6'd0);
        chk("dn_busy_on",  busys(), 6'b000101);
        step(8);                                          // at k+16
        chk("dn_busy_end", busys(), 6'd0);
        chk("dn_hold_mode", modes(), {2'd3, 2'd0, 2'd1});

        // Clean up press: a wraps 3->0, b 0->1, c 1->2. A down press lands 3 cycles
        // into hold-off and a second up press lands in its final cycle; both dropped.
        up = 1'b1; step(4); up = 1'b0; dn = 1'b1; step(3); // at k+6
        chk("up_pre_mode", modes(), {2'd3, 2'd0, 2'd1});
        chk("up_pre_mc",   mcs(),   6'd0);
        step(1);                                          // at k+7
        chk("up_mode", modes(), {2'd0, 2'd1, 2'd2});
        chk("up_mc",   mcs(),   6'b000111);
        chk("up_busy", busys(), 6'b000111);
        up = 1'b1; dn = 1'b0;
        step(1);                                          // at k+8
        chk("up_mc_off", mcs(), 6'd0);
        for (int i = 8; i <= 14; i++) begin
            chk("hold_busy", busys(), 6'b000111);
            chk("hold_mode", modes(), {2'd0, 2'd1, 2'd2});
            step(1);
        end                                               // at k+15
        chk("hold_end_busy", busys(), 6'd0);
        chk("hold_end_mode", modes(), {2'd0, 2'd1, 2'd2});
        step(1);                                          // at k+16
        chk("drop_mode", modes(), {2'd0, 2'd1, 2'd2});
        chk("drop_mc",   mcs(),   6'd0);
        chk("drop_busy", busys(), 6'd0);
        up = 1'b0;
        step(12);
        chk("held_no_retrigger", modes(), {2'd0, 2'd1, 2'd2});

        // Fresh press after hold-off: a 0->1, b 1->2, c 2->3.
        up = 1'b1; step(4); up = 1'b0; step(4);          // at k+7
        chk("fresh_mode", modes(), {2'd1, 2'd2, 2'd3});
        chk("fresh_mc",   mcs(),   6'b000111);
        step(9);
        chk("fresh_busy_end", busys(), 6'd0);

        // Up and down qualified in the same cycle: ignored everywhere.
        up = 1'b1; dn = 1'b1; step(4); up = 1'b0; dn = 1'b0; step(4); // at k+7
        chk("sim_mode", modes(), {2'd1, 2'd2, 2'd3});
        chk("sim_mc",   mcs(),   6'd0);
        chk("sim_busy", busys(), 6'd0);
        step(6);

        // Bounce: 2-cycle runs never reach 4 stable samples.
        for (int i = 0; i < 10; i++) begin
            up = (i % 2 == 0);
            step(2);
            chk("bounce_mode", modes(), {2'd1, 2'd2, 2'd3});
        end
        up = 1'b1; step(7);                               // at k+6
        chk("bounce_pre_mode", modes(), {2'd1, 2'd2, 2'd3});
        step(1);                                          // at k+7
        chk("bounce_mode_step", modes(), {2'd2, 2'd3, 2'd0});
        chk("bounce_mc",        mcs(),   6'b000111);
        step(3);
        chk("bounce_busy", busys(), 6'b000111);

        // Asynchronous reset in the middle of hold-off, between clock edges.
        #3 rst_n = 1'b0;
        #1;
        chk("midrst_mode", modes(), {2'd0, 2'd0, 2'd2});
        chk("midrst_busy", busys(), 6'd0);
        chk("midrst_mc",   mcs(),   6'd0);
        #1 up = 1'b0;
        rst_n = 1'b1;
        step(2);
        chk("post_rst_mode", modes(), {2'd0, 2'd0, 2'd2});
        chk("post_rst_busy", busys(), 6'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
